// File: rtl/turn_sequencer_if.sv
// Signal bundle between the turn sequencer and the sensor/timebase/motor-mux side.
// master = sequencer, slave = environment (sensors, timebase counter, multiplexer).
interface turn_sequencer_if #(
    parameter int COUNT_W = 21
);
    logic               sensor_l;
    logic               sensor_m;
    logic               sensor_r;
    logic [COUNT_W-1:0] count;
    logic [1:0]         turn_cmd;
    logic               count_reset;
    logic               motor_l_reset;
    logic               motor_r_reset;
    logic               motor_l_direction;
    logic               motor_r_direction;
    logic               turn_crossing_start;
    logic               done;
    logic               error;

    modport master (
        input  sensor_l, sensor_m, sensor_r, count, turn_cmd,
        output count_reset, motor_l_reset, motor_r_reset,
               motor_l_direction, motor_r_direction,
               turn_crossing_start, done, error
    );

    modport slave (
        output sensor_l, sensor_m, sensor_r, count, turn_cmd,
        input  count_reset, motor_l_reset, motor_r_reset,
               motor_l_direction, motor_r_direction,
               turn_crossing_start, done, error
    );
endinterface

// File: rtl/turn_sequencer.sv
// Crossing detector and turn sequencer: owns both motors from crossing detection
// until the commanded manoeuvre completes, then hands them back.
//
// state  | meaning
// IDLE   | line following owns motors, debouncing 3'b111
// DRIVE  | both motors forward to centre the axle on the crossing
// ROTATE | blind spin to leave the current line
// SEEK   | spin until the middle sensor finds a line, or time out
// FINISH | motors stopped, one-cycle done
// REARM  | ownership released, wait for sensors to leave the crossing
module turn_sequencer #(
    parameter int PERIOD_CYCLES = 2_000_000,
    parameter int COUNT_W       = 21,
    parameter int DEBOUNCE      = 16,
    parameter int FWD_PERIODS   = 10,
    parameter int MIN_ROT       = 15,
    parameter int UTURN_MIN     = 40,
    parameter int TIMEOUT       = 150
) (
    input  logic              clk,
    input  logic              reset,
    turn_sequencer_if.master  bus
);
    localparam int DEB_W  = $clog2(DEBOUNCE + 1);
    localparam int MAX_A  = (FWD_PERIODS > MIN_ROT) ? FWD_PERIODS : MIN_ROT;
    localparam int MAX_B  = (UTURN_MIN > TIMEOUT) ? UTURN_MIN : TIMEOUT;
    localparam int MAX_P  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int PER_W  = $clog2(MAX_P + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        ROTATE = 3'd2,
        SEEK   = 3'd3,
        FINISH = 3'd4,
        REARM  = 3'd5
    } state_t;

    state_t             state, state_next;
    logic [DEB_W-1:0]   deb_cnt;
    logic [PER_W-1:0]   period_cnt;
    logic [PER_W-1:0]   rot_last;
    logic [1:0]         cmd_q;
    logic               entry;
    logic               error_q;
    logic               timeout_hit;
    logic               all_black;
    logic               period_end;

    assign all_black  = bus.sensor_l & bus.sensor_m & bus.sensor_r;
    assign period_end = (bus.count >= COUNT_W'(PERIOD_CYCLES - 1));
    assign rot_last   = (cmd_q == 2'b11) ? PER_W'(UTURN_MIN - 1) : PER_W'(MIN_ROT - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            deb_cnt    <= '0;
            period_cnt <= '0;
            cmd_q      <= 2'b00;
            entry      <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state   <= state_next;
            entry   <= (state_next != state);
            error_q <= timeout_hit;
            if (state == IDLE && all_black && state_next == IDLE)
                deb_cnt <= deb_cnt + DEB_W'(1);
            else
                deb_cnt <= '0;
            if (state == IDLE && state_next == DRIVE)
                cmd_q <= bus.turn_cmd;
            // a state exit takes precedence over a coincident period end
            if (state_next != state)
                period_cnt <= '0;
            else if (period_end)
                period_cnt <= period_cnt + PER_W'(1);
        end
    end

    always_comb begin
        state_next  = state;
        timeout_hit = 1'b0;
        case (state)
            IDLE:
                if (all_black && deb_cnt == DEB_W'(DEBOUNCE - 1))
                    state_next = DRIVE;
            DRIVE:
                if (period_end && period_cnt == PER_W'(FWD_PERIODS - 1))
                    state_next = (cmd_q == 2'b00) ? FINISH : ROTATE;
            ROTATE:
                if (period_end && period_cnt == rot_last)
                    state_next = SEEK;
            SEEK:
                if (bus.sensor_m)
                    state_next = FINISH;
                else if (period_end && period_cnt == PER_W'(TIMEOUT - 1)) begin
                    state_next  = REARM;
                    timeout_hit = 1'b1;
                end
            FINISH:
                state_next = REARM;
            REARM:
                if (!all_black)
                    state_next = IDLE;
            default:
                state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.turn_crossing_start = 1'b0;
        bus.motor_l_reset       = 1'b1;
        bus.motor_r_reset       = 1'b1;
        bus.motor_l_direction   = 1'b0;
        bus.motor_r_direction   = 1'b0;
        bus.done                = 1'b0;
        bus.error               = error_q;
        bus.count_reset         = entry | period_end;
        case (state)
            IDLE, REARM:
                bus.count_reset = 1'b1;
            DRIVE: begin
                bus.turn_crossing_start = 1'b1;
                bus.motor_l_reset       = 1'b0;
                bus.motor_r_reset       = 1'b0;
                bus.motor_l_direction   = 1'b1;
                bus.motor_r_direction   = 1'b0;
            end
            ROTATE, SEEK: begin
                // left turn spins counter-clockwise; right and U-turn clockwise
                bus.turn_crossing_start = 1'b1;
                bus.motor_l_reset       = 1'b0;
                bus.motor_r_reset       = 1'b0;
                bus.motor_l_direction   = (cmd_q != 2'b01);
                bus.motor_r_direction   = (cmd_q != 2'b01);
            end
            FINISH: begin
                bus.turn_crossing_start = 1'b1;
                bus.done                = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_turn_sequencer.sv
// Directed bench for turn_sequencer with a modelled timebase counter.
module tb_turn_sequencer;
    localparam int CW = 8;

    typedef struct {
        logic [1:0] cmd;
        int         m_at;
        int         exp_drive;
        int         exp_spin;
        int         exp_ldir;
        int         exp_rdir;
        int         exp_done;
        int         exp_error;
    } vec_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;
    vec_t vecs[5];

    turn_sequencer_if #(.COUNT_W(CW)) bus ();

    turn_sequencer #(
        .PERIOD_CYCLES(10),
        .COUNT_W      (CW),
        .DEBOUNCE     (3),
        .FWD_PERIODS  (2),
        .MIN_ROT      (1),
        .UTURN_MIN    (3),
        .TIMEOUT      (8)
    ) dut (
        .clk  (clk),
        .reset(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               bus.count <= '0;
        else if (bus.count_reset) bus.count <= '0;
        else                      bus.count <= bus.count + CW'(1);
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_sensors(input logic [2:0] s);
        {bus.sensor_l, bus.sensor_m, bus.sensor_r} = s;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cr"},   bus.count_reset, 1);
        check({tag, "_lrst"}, bus.motor_l_reset, 1);
        check({tag, "_rrst"}, bus.motor_r_reset, 1);
        check({tag, "_ldir"}, bus.motor_l_direction, 0);
        check({tag, "_rdir"}, bus.motor_r_direction, 0);
        check({tag, "_tcs"},  bus.turn_crossing_start, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_err"},  bus.error, 0);
    endtask

    task automatic run_row(input int idx, input vec_t v);
        int drive, spin, budget, early, dir_bad, spin_l, spin_r;
        string tag;
        tag = $sformatf("row%0d", idx);
        drive = 0; spin = 0; budget = 0; early = 0; dir_bad = 0; spin_l = -1; spin_r = -1;
        set_sensors(3'b111);
        bus.turn_cmd = v.cmd;
        repeat (2) @(negedge clk);
        check({tag, "_prestart"}, bus.turn_crossing_start, 0);
        @(negedge clk);
        check({tag, "_start"}, bus.turn_crossing_start, 1);
        bus.turn_cmd = ~v.cmd;
        if (v.cmd != 2'b00) set_sensors(3'b000);
        while (budget < 400) begin
            if (!bus.motor_l_reset && !bus.motor_r_reset && bus.motor_l_direction
                && !bus.motor_r_direction && spin == 0) begin
                drive++;
            end else if (!bus.motor_l_reset && !bus.motor_r_reset) begin
                spin++;
                if (spin == 1) begin
                    spin_l = int'(bus.motor_l_direction);
                    spin_r = int'(bus.motor_r_direction);
                end else if (spin_l != int'(bus.motor_l_direction)
                             || spin_r != int'(bus.motor_r_direction)) begin
                    dir_bad++;
                end
                if (spin == v.m_at) set_sensors(3'b010);
            end else begin
                break;
            end
            if (bus.done || bus.error) early++;
            @(negedge clk);
            budget++;
        end
        check({tag, "_budget"}, int'(budget < 400), 1);
        check({tag, "_drive"}, drive, v.exp_drive);
        check({tag, "_spin"}, spin, v.exp_spin);
        check({tag, "_early"}, early, 0);
        if (v.exp_spin > 0) begin
            check({tag, "_spin_ldir"}, spin_l, v.exp_ldir);
            check({tag, "_spin_rdir"}, spin_r, v.exp_rdir);
            check({tag, "_dir_stable"}, dir_bad, 0);
        end
        check({tag, "_done"}, bus.done, v.exp_done);
        check({tag, "_error"}, bus.error, v.exp_error);
        check({tag, "_exit_tcs"}, bus.turn_crossing_start, v.exp_done);
        @(negedge clk);
        check({tag, "_done_fall"}, bus.done, 0);
        check({tag, "_error_fall"}, bus.error, 0);
        check({tag, "_tcs_fall"}, bus.turn_crossing_start, 0);
        if (v.cmd == 2'b00) begin
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                check({tag, "_rearm_hold"}, bus.turn_crossing_start, 0);
            end
        end
        set_sensors(3'b000);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [2:0] pat [5];
        n_cmp = 0;
        n_bad = 0;
        //        cmd    m_at drive spin ldir rdir done err
        vecs[0] = '{2'b00,   0,  21,   0,   0,   0,   1,  0};
        vecs[1] = '{2'b01,  42,  21,  42,   0,   0,   1,  0};
        vecs[2] = '{2'b10,   5,  21,  12,   1,   1,   1,  0};
        vecs[3] = '{2'b11,   0,  21, 112,   1,   1,   0,  1};
        vecs[4] = '{2'b11, 112,  21, 112,   1,   1,   1,  0};
        pat[0] = 3'b111; pat[1] = 3'b111; pat[2] = 3'b011; pat[3] = 3'b111; pat[4] = 3'b111;

        rst_n = 1'b0;
        set_sensors(3'b000);
        bus.turn_cmd = 2'b00;
        #1;
        check_reset_values("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) run_row(i, vecs[i]);

        bus.turn_cmd = 2'b10;
        for (int i = 0; i < 5; i++) begin
            set_sensors(pat[i]);
            @(negedge clk);
            check($sformatf("glitch%0d_nostart", i), bus.turn_crossing_start, 0);
        end
        set_sensors(3'b111);
        @(negedge clk);
        check("glitch_start", bus.turn_crossing_start, 1);

        set_sensors(3'b000);
        repeat (40) @(negedge clk);
        check("seek_running", int'(!bus.motor_l_reset && bus.motor_l_direction
                                   && bus.motor_r_direction), 1);
        rst_n = 1'b0;
        #1;
        check_reset_values("midseek");
        set_sensors(3'b111);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_reset_nostart", bus.turn_crossing_start, 0);
        @(negedge clk);
        check("post_reset_start", bus.turn_crossing_start, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/turn_sequencer.md
# turn_sequencer

Crossing and turn sequencer for the line follower. It detects a crossing from the three line sensors, takes ownership of both motors, and asserts `turn_crossing_start` so the motor-source multiplexer routes its outputs instead of the line-following controller's. It then drives the robot straight over the crossing, executes the commanded manoeuvre, and hands the motors back. Its outputs feed the `*_turns_crossing` inputs of the multiplexer, which forwards them to the two motor controllers and the shared 20 ms timebase counter.

## Interface

- `PERIOD_CYCLES`, default 2_000_000: timebase period in clocks (20 ms at 100 MHz).
- `COUNT_W`, default 21: width of the timebase count.
- `DEBOUNCE`, default 16: consecutive cycles the sensors must read 3'b111 to confirm a crossing.
- `FWD_PERIODS`, default 10: periods spent driving straight to centre the axle on the crossing.
- `MIN_ROT`, default 15: blind rotation periods for left/right turns, used to leave the current line.
- `UTURN_MIN`, default 40: blind rotation periods for a U-turn.
- `TIMEOUT`, default 150: maximum periods allowed in SEEK.

Ports:

- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `sensor_l`, `sensor_m`, `sensor_r` in 1 each: line sensors, 1 = black.
- `count` in COUNT_W: timebase counter value.
- `turn_cmd` in 2: manoeuvre to execute. 00 = straight, 01 = left, 10 = right, 11 = U-turn.
- `count_reset` out 1: timebase reset request.
- `motor_l_reset`, `motor_r_reset` out 1 each: 1 = motor stopped.
- `motor_l_direction`, `motor_r_direction` out 1 each: left forward = 1; right forward = 0 (mirrored mounting).
- `turn_crossing_start` out 1: 1 = this block owns the motors.
- `done` out 1: one-cycle pulse on successful completion.
- `error` out 1: one-cycle pulse on SEEK timeout.

## Operation

**States:** IDLE, DRIVE, ROTATE, SEEK, FINISH, REARM.

**Debounce and arming**
- A debounce counter increments while sensors == 3'b111 and clears otherwise.
- IDLE → DRIVE when the debounce counter reaches DEBOUNCE-1 with sensors still 3'b111.
- `turn_cmd` is latched on that same edge. Later changes to `turn_cmd` are ignored until the next crossing.

**Period counting**
- A period ends when `count >= PERIOD_CYCLES-1`.
- `period_cnt` increments at each period end and clears on every state transition.

**State transitions and motor drive**
- DRIVE: both motors forward. After FWD_PERIODS completed periods:
  - latched command 00 → FINISH;
  - otherwise → ROTATE.
- ROTATE: spin in place.
  - Left (01): left motor backward, right motor forward.
  - Right (10) and U-turn (11): left motor forward, right motor backward.
  - Exits to SEEK after MIN_ROT periods (UTURN_MIN for a U-turn).
- SEEK: same spin direction as ROTATE.
  - → FINISH on the first cycle `sensor_m == 1`.
  - → REARM with an `error` pulse when `period_cnt` reaches TIMEOUT.
- FINISH: motors stopped. Exactly one cycle; `done` = 1. Then → REARM.
- REARM: ownership released. → IDLE once sensors != 3'b111 for one cycle, so the crossing just handled is not re-detected.

**Outputs**
- `turn_crossing_start` = 1 in DRIVE, ROTATE, SEEK and FINISH; 0 in IDLE and REARM.
- `motor_*_reset` = 0 in DRIVE, ROTATE and SEEK; 1 elsewhere.
- `motor_*_direction` = 0 in IDLE and REARM.
- `count_reset` (combinational) = 1 in any of these cases:
  - in IDLE or REARM;
  - in the first cycle of each active state (entry flag);
  - when `count >= PERIOD_CYCLES-1`.
- All other outputs are decoded from the state register (Moore).

## Timing

- **Reset values:** state IDLE, all counters 0, `count_reset` = 1, `motor_l_reset` = `motor_r_reset` = 1, both directions 0, `turn_crossing_start` = 0, `done` = 0, `error` = 0.
- **Reset mid-manoeuvre:** asserting `reset` in any state returns to IDLE immediately, with the values above.
- **Detection latency:** `turn_crossing_start` rises on the clock edge after DEBOUNCE consecutive 3'b111 samples.
- **Debounce glitch:** any non-111 sample restarts the debounce count.
- **Period end vs. state exit:** if a period end and a state exit coincide, the exit wins and `period_cnt` clears rather than increments.
- **SEEK priority:** `sensor_m == 1` in the same cycle the timeout is reached → FINISH (success wins).
- **FINISH duration:** exactly one cycle. `done` and `turn_crossing_start` fall together on leaving FINISH.

## Test plan

Parameters for all scenarios: PERIOD_CYCLES=10, DEBOUNCE=3, FWD_PERIODS=2, MIN_ROT=1, UTURN_MIN=3, TIMEOUT=8. The bench models the timebase counter: increment each cycle, clear on `count_reset`.

1. **Straight:** sensors 111 for 3 cycles with `turn_cmd`=00 → `turn_crossing_start` rises; both motors forward (l_dir=1, r_dir=0) for 2 periods; one `done` pulse; REARM holds until sensors leave 111.
2. **Left:** `turn_cmd`=01; `sensor_m` goes 1 after 3 periods in SEEK → ROTATE/SEEK show l_dir=0, r_dir=0; `done` pulses on the cycle after `sensor_m` rises.
3. **Debounce glitch:** pattern 111,111,011,111,111 → no start. A third consecutive 111 → start.
4. **U-turn timeout:** `turn_cmd`=11 and `sensor_m` held 0 → exactly 3 ROTATE periods plus 8 SEEK periods, then `error` = 1 for one cycle; `done` never pulses.
5. **Timeout collision:** `sensor_m` rises on the same cycle TIMEOUT is reached → `done` = 1 and `error` = 0.
6. **Reset mid-SEEK:** assert `reset` low during SEEK → all outputs at reset values immediately. After release, no start until a fresh debounced 111.
